keypad_entry: RTL

// - Front-end for microwave time entry: synchronizes and debounces the 10-key one-hot keypad,

---
 rtl/keypad_entry.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: synchronizes and debounces a one-hot 10-key keypad into a 3-digit M:ST:SO BCD
// buffer and hands it to the down-counter on start. Build option: KEYPAD_CLAMP_EN (seconds-tens clamp).
//
// state    | meaning
// IDLE     | no candidate key; waiting for a one-hot sample
// DEBOUNCE | counting consecutive identical samples of the latched code
// HELD     | key accepted; waiting for every key bit to be released
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int DB_W            = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       mag_on,
    output logic [3:0] entry_min,
    output logic [3:0] entry_tens,
    output logic [3:0] entry_ones,
    output logic       entry_valid,
    output logic       key_strobe,
    output logic       load_pulse
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [9:0]      ks1, ks2;
    logic [3:0]      code, code_next, ks2_code;
    logic            ks2_onehot;
    logic [DB_W-1:0] db_cnt, db_cnt_next;
    logic            accept;
    logic [1:0]      digit_cnt;
    logic            startn_q;
    logic            start_fall;
    logic            load_fire;
    logic [3:0]      tens_in;

    always_comb begin
        ks2_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (ks2[i]) ks2_code = 4'(i);
        end
    end

    assign ks2_onehot = $onehot(ks2);

    always_ff @(posedge clk) begin
        if (clear) begin
            state  <= IDLE;
            code   <= 4'd0;
            db_cnt <= '0;
        end else begin
            state  <= state_next;
            code   <= code_next;
            db_cnt <= db_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        code_next   = code;
        db_cnt_next = db_cnt;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (ks2_onehot) begin
                    state_next  = DEBOUNCE;
                    code_next   = ks2_code;
                    db_cnt_next = DB_W'(1);
                end
            end
            DEBOUNCE: begin
                if (ks2_onehot && (ks2_code == code)) begin
                    if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_next  = HELD;
                        accept      = 1'b1;
                        db_cnt_next = '0;
                    end else begin
                        db_cnt_next = db_cnt + DB_W'(1);
                    end
                end else begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end
            end
            HELD: begin
                if (ks2 == 10'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The digit moving from ones into tens is the only one that can break the seconds range.
`ifdef KEYPAD_CLAMP_EN
    assign tens_in     = (entry_ones > 4'd5) ? 4'd5 : entry_ones;
    assign entry_valid = (digit_cnt != 2'd0);
`else
    assign tens_in     = entry_ones;
    assign entry_valid = (digit_cnt != 2'd0) && (entry_tens <= 4'd5);
`endif

    assign start_fall = startn_q & ~startn;
    assign load_fire  = start_fall & ~mag_on & entry_valid;

    always_ff @(posedge clk) begin
        if (clear) begin
            ks1        <= 10'd0;
            ks2        <= 10'd0;
            startn_q   <= 1'b1;
            entry_min  <= 4'd0;
            entry_tens <= 4'd0;
            entry_ones <= 4'd0;
            digit_cnt  <= 2'd0;
            key_strobe <= 1'b0;
            load_pulse <= 1'b0;
        end else begin
            ks1        <= keypad;
            ks2        <= ks1;
            startn_q   <= startn;
            load_pulse <= load_fire;
            key_strobe <= 1'b0;
            // A start in the same cycle as an accept takes priority; that digit is lost.
            if (load_pulse) begin
                entry_min  <= 4'd0;
                entry_tens <= 4'd0;
                entry_ones <= 4'd0;
                digit_cnt  <= 2'd0;
            end else if (!load_fire && accept && !mag_on) begin
                entry_min  <= entry_tens;
                entry_tens <= tens_in;
                entry_ones <= code;
                key_strobe <= 1'b1;
                if (digit_cnt != 2'd3) digit_cnt <= digit_cnt + 2'd1;
            end
        end
    end

endmodule
